demux1_4_64bit_fifo: RTL and testbench



---
 rtl/demux1_4_64bit_fifo_pkg.sv | 17 +
 rtl/demux1_4_64bit_fifo_fifo2.sv | 53 +++++
 rtl/demux1_4_64bit_fifo.sv | 51 +++++
 tb/tb_demux1_4_64bit_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/demux1_4_64bit_fifo_pkg.sv
// Shared widths and helpers for the buffered 1-to-4 64-bit demultiplexer.
package demux1_4_64bit_fifo_pkg;

  localparam int unsigned DEMUX_WIDTH    = 64;
  localparam int unsigned DEMUX_DEPTH    = 2;
  localparam int unsigned DEMUX_CHANNELS = 4;
  localparam int unsigned DEMUX_SEL_W    = 2;

  typedef logic [DEMUX_WIDTH-1:0]    word_t;
  typedef logic [DEMUX_CHANNELS-1:0] chan_mask_t;
  typedef logic [DEMUX_SEL_W-1:0]    chan_sel_t;

  function automatic chan_mask_t sel_onehot(input chan_sel_t sel);
    return chan_mask_t'(1) << sel;
  endfunction

endpackage

// File: rtl/demux1_4_64bit_fifo_fifo2.sv
// Two-entry 64-bit FIFO; head word is forced to zero while empty.
module fifo2_64bit
  import demux1_4_64bit_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] wdata,
  input  logic        pop,
  output logic [63:0] rdata,
  output logic        empty,
  output logic        full
);

  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, wr_ptr_q;
  word_t      mem_q [DEMUX_DEPTH];
  logic       do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: rdata is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/demux1_4_64bit_fifo.sv
// Buffered 1-to-4 demultiplexer: routes each accepted word to a per-channel 2-entry FIFO.
module demux1_4_64bit_fifo
  import demux1_4_64bit_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in,
  input  logic [1:0]  sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out0,
  output logic [63:0] out1,
  output logic [63:0] out2,
  output logic [63:0] out3,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready
);

  chan_mask_t full, empty, push_en, pop_en;
  word_t      rdata [DEMUX_CHANNELS];

  // in_ready looks only at registered fullness, never at out_ready.
  assign in_ready = ~full[sel];

  always_comb begin
    push_en = '0;
    if (in_valid && in_ready) push_en = sel_onehot(sel);
  end

  assign out_valid = ~empty;
  assign pop_en    = out_valid & out_ready;

  for (genvar n = 0; n < DEMUX_CHANNELS; n++) begin : g_chan
    fifo2_64bit u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en[n]),
      .wdata (in),
      .pop   (pop_en[n]),
      .rdata (rdata[n]),
      .empty (empty[n]),
      .full  (full[n])
    );
  end

  assign out0 = rdata[0];
  assign out1 = rdata[1];
  assign out2 = rdata[2];
  assign out3 = rdata[3];

endmodule

// File: tb/tb_demux1_4_64bit_fifo.sv
// Scoreboard bench: per-channel expected queues filled on acceptance, drained by a monitor.
module tb_demux1_4_64bit_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;

  logic [63:0] outs [4];
  logic [63:0] q [4][$];
  int          checks = 0;
  int          passed = 0;
  bit          run = 1'b0;

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;

  always #5 clk = ~clk;

  demux1_4_64bit_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
  endtask

  task automatic clear_model();
    for (int n = 0; n < 4; n++) q[n].delete();
  endtask

  // Monitor: mid-cycle, compare visible state to the model and retire popped words.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, q[sel].size() < 2});
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("out_valid[%0d]", n), {63'd0, out_valid[n]}, {63'd0, q[n].size() > 0});
        if (q[n].size() > 0) begin
          chk($sformatf("out%0d", n), outs[n], q[n][0]);
          if (out_ready[n]) void'(q[n].pop_front());
        end else begin
          chk($sformatf("out%0d_empty", n), outs[n], 64'd0);
        end
      end
    end
  end

  // Called at posedge+1; applies inputs for the next edge and records acceptance.
  task automatic drive(input bit v, input logic [1:0] s, input logic [63:0] d,
                       input logic [3:0] rdy);
    bit acc;
    in_valid  = v;
    sel       = s;
    in        = d;
    out_ready = rdy;
    acc = v && (q[s].size() < 2);
    @(posedge clk);
    if (acc) q[s].push_back(d);
    #1;
  endtask

  initial begin
    logic [63:0] wa, wb;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    run = 1'b1;

    // Reset then idle.
    chk("reset_out_valid", {60'd0, out_valid}, 64'd0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #0;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out", outs[s], 64'd0);
    end

    // Single route to channel 2.
    drive(1'b1, 2'd2, 64'hDEAD_BEEF_0123_4567, 4'b0000);
    in_valid = 1'b0;
    chk("route_valid", {60'd0, out_valid}, 64'h4);
    chk("route_out2", out2, 64'hDEAD_BEEF_0123_4567);
    chk("route_out0", out0, 64'd0);
    drive(1'b0, 2'd0, 64'd0, 4'b0100);
    chk("route_drained", {60'd0, out_valid}, 64'd0);

    // Fill channel 1, then check backpressure ignores out_ready.
    wa = 64'hAAAA_0000_1111_2222;
    wb = 64'hBBBB_3333_4444_5555;
    drive(1'b1, 2'd1, wa, 4'b0000);
    drive(1'b1, 2'd1, wb, 4'b0000);
    sel = 2'd1; out_ready = 4'b0010; in_valid = 1'b1; in = 64'hFFFF;
    #1;
    chk("full_in_ready_sel1", {63'd0, in_ready}, 64'd0);
    sel = 2'd0;
    #1;
    chk("full_in_ready_sel0", {63'd0, in_ready}, 64'd1);
    #1;
    chk("full_head_A", out1, wa);
    drive(1'b0, 2'd1, 64'd0, 4'b0010);
    chk("pop_head_B", out1, wb);
    drive(1'b0, 2'd1, 64'd0, 4'b0010);
    chk("pop_done", {60'd0, out_valid}, 64'd0);

    // Concurrent push/pop on channel 3 with one word held.
    drive(1'b1, 2'd3, 64'h1234, 4'b0000);
    drive(1'b1, 2'd3, 64'h5678, 4'b1000);
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("pushpop_out3", out3, 64'h5678);
    chk("pushpop_valid", {60'd0, out_valid}, 64'h8);
    drive(1'b0, 2'd0, 64'd0, 4'b1000);

    // Round-robin into all channels with every consumer ready.
    for (int i = 0; i < 8; i++) drive(1'b1, 2'(i % 4), 64'(i % 4 + 1), 4'b1111);
    drive(1'b0, 2'd0, 64'd0, 4'b1111);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      drive(($urandom % 4) != 0, 2'($urandom), {$urandom, $urandom}, 4'($urandom));

    // Mid-operation asynchronous reset with channels 0 and 1 full.
    drive(1'b0, 2'd0, 64'd0, 4'b1111);
    drive(1'b1, 2'd0, 64'h10, 4'b0000);
    drive(1'b1, 2'd0, 64'h11, 4'b0000);
    drive(1'b1, 2'd1, 64'h20, 4'b0000);
    drive(1'b1, 2'd1, 64'h21, 4'b0000);
    in_valid = 1'b0;
    chk("pre_reset_valid", {60'd0, out_valid}, 64'h3);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("async_rst_valid", {60'd0, out_valid}, 64'd0);
    chk("async_rst_out0", out0, 64'd0);
    chk("async_rst_out1", out1, 64'd0);
    sel = 2'd1;
    #0;
    chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 2'd0, 64'hC0FFEE, 4'b0000);
    in_valid = 1'b0;
    chk("post_rst_push", out0, 64'hC0FFEE);
    drive(1'b0, 2'd0, 64'd0, 4'b1111);
    drive(1'b0, 2'd0, 64'd0, 4'b0000);

    run = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit reached");
  end

endmodule
